// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// The stage drives the request side; memory returns read data and ack.
interface mem_wb_stage_if #(
  parameter int DATA_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage with MEM/WB register, variable-latency access and timeout abort.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_wb_stage #(
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] Result_2,
  input  logic [DATA_W-1:0] ReadData2_3,
  input  logic [4:0]        rd_3,
  input  logic              MemtoReg_3,
  input  logic              MemRead_3,
  input  logic              MemWrite_3,
  input  logic              RegWrite_3,
  mem_wb_stage_if.master    mem,
  output logic              mem_stall,
  output logic              mem_err,
  output logic [DATA_W-1:0] ReadData_wb,
  output logic [DATA_W-1:0] Result_wb,
  output logic [4:0]        rd_wb,
  output logic              MemtoReg_wb,
  output logic              RegWrite_wb
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [4:0]        rd_q, rd_d;
  logic              mtr_q, mtr_d;
  logic              rw_q, rw_d;

  logic access;
  logic misalign;
  logic go;
  logic timeout;
  logic stall;
  logic req;
  logic capture;
  logic rd_ack;

  assign access = MemRead_3 | MemWrite_3;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = access & (Result_2[2:0] != 3'b000);
`else
  assign misalign = 1'b0;
`endif

  // A trapped misaligned access never reaches the memory bus.
  assign go = access & ~misalign;

  assign timeout = (state_q == S_WAIT)
                 & ~mem.mem_ack
                 & (cnt_q == TO_LIM);

  assign stall = go & ~mem.mem_ack & ~timeout;

  assign mem.mem_addr  = Result_2;
  assign mem.mem_wdata = ReadData2_3;
  assign mem.mem_we    = MemWrite_3;
  assign mem.mem_req   = req;

  assign mem_stall = stall;
  assign mem_err   = timeout | misalign;

  assign ReadData_wb = rdata_q;
  assign Result_wb   = res_q;
  assign rd_wb       = rd_q;
  assign MemtoReg_wb = mtr_q;
  assign RegWrite_wb = rw_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req = go;
        if (go && !mem.mem_ack) begin
          state_d = S_WAIT;
          cnt_d   = 8'd1;
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (mem.mem_ack || timeout) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    // Reset abandons the access on the bus right away.
    if (reset) begin
      req = 1'b0;
    end
  end

  assign capture = ~stall & ~timeout & ~misalign;
  assign rd_ack  = go & MemRead_3 & ~MemWrite_3 & mem.mem_ack;

  always_comb begin
    rdata_d = rdata_q;
    res_d   = res_q;
    rd_d    = rd_q;
    mtr_d   = mtr_q;
    rw_d    = rw_q;
    if (capture) begin
      res_d = Result_2;
      rd_d  = rd_3;
      mtr_d = MemtoReg_3;
      rw_d  = RegWrite_3;
      if (rd_ack) begin
        rdata_d = mem.mem_rdata;
      end
    end else begin
      rd_d  = 5'd0;
      mtr_d = 1'b0;
      rw_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      res_q   <= '0;
      rd_q    <= 5'd0;
      mtr_q   <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      mtr_q   <= mtr_d;
      rw_q    <= rw_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_mem_wb_stage;

  localparam int DW = 64;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] Result_2, ReadData2_3;
  logic [4:0]    rd_3;
  logic          MemtoReg_3, MemRead_3, MemWrite_3, RegWrite_3;
  logic          mem_stall, mem_err;
  logic [DW-1:0] ReadData_wb, Result_wb;
  logic [4:0]    rd_wb;
  logic          MemtoReg_wb, RegWrite_wb;

  mem_wb_stage_if #(.DATA_W(DW)) mif ();

  mem_wb_stage #(
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Result_2   (Result_2),
    .ReadData2_3(ReadData2_3),
    .rd_3       (rd_3),
    .MemtoReg_3 (MemtoReg_3),
    .MemRead_3  (MemRead_3),
    .MemWrite_3 (MemWrite_3),
    .RegWrite_3 (RegWrite_3),
    .mem        (mif.master),
    .mem_stall  (mem_stall),
    .mem_err    (mem_err),
    .ReadData_wb(ReadData_wb),
    .Result_wb  (Result_wb),
    .rd_wb      (rd_wb),
    .MemtoReg_wb(MemtoReg_wb),
    .RegWrite_wb(RegWrite_wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    logic [DW-1:0] wd;
    logic [4:0]    rd;
    logic          mtr, mr, mw, rw;
  } instr_t;

  typedef struct {
    logic          req, we, stall, err;
    logic [DW-1:0] addr, wdata;
    logic [DW-1:0] rdata_wb, res_wb;
    logic [4:0]    rd_wb;
    logic          mtr_wb, rw_wb;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Architectural view of the write-back register.
  logic [DW-1:0] m_rdata, m_res;
  logic [4:0]    m_rd;
  logic          m_mtr, m_rw;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, ex, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("mem_req",   DW'(mif.mem_req),   DW'(e.req));
      chk("mem_we",    DW'(mif.mem_we),    DW'(e.we));
      chk("mem_addr",  mif.mem_addr,       e.addr);
      chk("mem_wdata", mif.mem_wdata,      e.wdata);
      chk("mem_stall", DW'(mem_stall),     DW'(e.stall));
      chk("mem_err",   DW'(mem_err),       DW'(e.err));
      chk("ReadData_wb", ReadData_wb,      e.rdata_wb);
      chk("Result_wb",   Result_wb,        e.res_wb);
      chk("rd_wb",       DW'(rd_wb),       DW'(e.rd_wb));
      chk("MemtoReg_wb", DW'(MemtoReg_wb), DW'(e.mtr_wb));
      chk("RegWrite_wb", DW'(RegWrite_wb), DW'(e.rw_wb));
    end
  end

  function automatic void model_clear();
    m_rdata = '0;
    m_res   = '0;
    m_rd    = 5'd0;
    m_mtr   = 1'b0;
    m_rw    = 1'b0;
  endfunction

  function automatic void model_bubble();
    m_rd  = 5'd0;
    m_mtr = 1'b0;
    m_rw  = 1'b0;
  endfunction

  task automatic drive(instr_t in, logic ack, logic [DW-1:0] rdata);
    Result_2      = in.res;
    ReadData2_3   = in.wd;
    rd_3          = in.rd;
    MemtoReg_3    = in.mtr;
    MemRead_3     = in.mr;
    MemWrite_3    = in.mw;
    RegWrite_3    = in.rw;
    mif.mem_ack   = ack;
    mif.mem_rdata = rdata;
  endtask

  task automatic push(instr_t in, logic req, logic stall, logic err);
    exp_t e;
    e.req      = req;
    e.we       = in.mw;
    e.addr     = in.res;
    e.wdata    = in.wd;
    e.stall    = stall;
    e.err      = err;
    e.rdata_wb = m_rdata;
    e.res_wb   = m_res;
    e.rd_wb    = m_rd;
    e.mtr_wb   = m_mtr;
    e.rw_wb    = m_rw;
    exp_q.push_back(e);
  endtask

  // One instruction whose memory answers after lat wait cycles.
  task automatic run_instr(instr_t in, int lat, logic [DW-1:0] rd_val);
    bit acc, mis, real_acc, tmo;
    int n;
    acc = in.mr || in.mw;
`ifdef MEM_ALIGN_CHECK_EN
    mis = acc && (in.res[2:0] != 3'b000);
`else
    mis = 1'b0;
`endif
    real_acc = acc && !mis;
    tmo      = real_acc && (lat > TO);
    n        = !real_acc ? 0 : (lat <= TO ? lat : TO);
    for (int c = 0; c <= n; c++) begin
      logic ack;
      logic [DW-1:0] rv;
      rv  = {$urandom, $urandom};
      ack = real_acc ? (c == lat) : 1'($urandom);
      if (real_acc && c == lat) rv = rd_val;
      drive(in, ack, rv);
      push(in, real_acc, real_acc && (c < n),
           (c == n) && (tmo || mis));
      if (c < n || tmo || mis) begin
        model_bubble();
      end else begin
        m_res = in.res;
        m_rd  = in.rd;
        m_mtr = in.mtr;
        m_rw  = in.rw;
        if (real_acc && in.mr && !in.mw) m_rdata = rv;
      end
      @(posedge clk);
      #1;
    end
  endtask

  function automatic instr_t mk(logic [DW-1:0] res, logic [DW-1:0] wd,
                                logic [4:0] rd, logic mtr, logic mr,
                                logic mw, logic rw);
    instr_t i;
    i.res = res; i.wd = wd; i.rd = rd;
    i.mtr = mtr; i.mr = mr; i.mw = mw; i.rw = rw;
    return i;
  endfunction

  initial begin
    instr_t nop, ld;
    nop   = mk('0, '0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    drive(nop, 1'b0, '0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(nop, 0, '0);
    // zero-wait load
    run_instr(mk(64'h100, '0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1), 0, 64'hDEAD);
    // 3-wait store
    run_instr(mk(64'h200, 64'h55, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0), 3, '0);
    // load never acked -> timeout
    run_instr(mk(64'h300, '0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1), 1000, '0);
    // ALU op
    run_instr(mk(64'h7, '0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1), 0, '0);
    // misaligned load
    run_instr(mk(64'h103, '0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1), 1, 64'hBEEF);
    // ack exactly at the timeout boundary wins
    run_instr(mk(64'h308, '0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1), TO, 64'hACE);
    // both read and write set behaves as a write
    run_instr(mk(64'h310, 64'h99, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1), 1, 64'h1);

    // reset in the middle of a wait
    ld = mk(64'h400, '0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      drive(ld, 1'b0, '0);
      push(ld, 1'b1, 1'b1, 1'b0);
      model_bubble();
      @(posedge clk);
      #1;
    end
    drive(ld, 1'b0, '0);
    #2;
    reset = 1'b1;
    model_clear();
    push(ld, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_instr(nop, 0, '0);

    for (int k = 0; k < 300; k++) begin
      instr_t r;
      int lat;
      r.res = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) r.res[2:0] = 3'b000;
      r.wd  = {$urandom, $urandom};
      r.rd  = 5'($urandom);
      r.mtr = 1'($urandom);
      r.mr  = ($urandom_range(0, 2) == 0);
      r.mw  = ($urandom_range(0, 3) == 0);
      r.rw  = 1'($urandom);
      lat   = $urandom_range(0, 7);
      run_instr(r, lat, {$urandom, $urandom});
    end

    drive(nop, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
